// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port.
// Retires one pending write per cycle in order and forwards pending data.
module regfile_wb_queue #(
    parameter int N     = 32,
    parameter int R     = 5,
    parameter int DEPTH = 4,
    parameter int P     = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [R-1:0] in_wa,
    input  logic [N-1:0] in_wd,
    output logic [R-1:0] wa,
    output logic [N-1:0] wd,
    output logic         wen,
    input  logic [R-1:0] raA,
    input  logic [R-1:0] raB,
    output logic         hitA,
    output logic         hitB,
    output logic [N-1:0] fwdA,
    output logic [N-1:0] fwdB,
    output logic [P:0]   count,
    output logic         empty
);

    logic [R-1:0]     q_wa [DEPTH];
    logic [N-1:0]     q_wd [DEPTH];
    logic [DEPTH-1:0] q_v;
    logic [P-1:0]     head;
    logic [P-1:0]     tail;
    logic [P:0]       cnt;
    logic             push;
    logic             pop;

    assign in_ready = (cnt != (P+1)'(DEPTH));
    // Writes to r0 complete the handshake but are dropped here.
    assign push     = in_valid & in_ready & (in_wa != '0);
    assign pop      = (cnt != '0);
    assign count    = cnt;
    assign empty    = (cnt == '0) & ~wen;

    // Pointers, occupancy, valid bits and the registered write port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            q_v  <= '0;
            wa   <= '0;
            wd   <= '0;
            wen  <= 1'b0;
        end else begin
            if (pop) begin
                wa        <= q_wa[head];
                wd        <= q_wd[head];
                wen       <= 1'b1;
                q_v[head] <= 1'b0;
                head      <= head + 1'b1;
            end else begin
                wen <= 1'b0;
            end
            if (push) begin
                q_v[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload storage; validity is tracked by q_v so no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            q_wa[tail] <= in_wa;
            q_wd[tail] <= in_wd;
        end
    end

    // Forwarding: output stage first, then entries oldest to youngest so
    // the youngest match wins.
    always_comb begin
        logic [P-1:0] ia;
        hitA = 1'b0;
        hitB = 1'b0;
        fwdA = '0;
        fwdB = '0;
        ia   = '0;
        if (wen && wa == raA && raA != '0) begin
            hitA = 1'b1;
            fwdA = wd;
        end
        if (wen && wa == raB && raB != '0) begin
            hitB = 1'b1;
            fwdB = wd;
        end
        for (int i = 0; i < DEPTH; i++) begin
            ia = head + P'(i);
            if (q_v[ia] && q_wa[ia] == raA && raA != '0) begin
                hitA = 1'b1;
                fwdA = q_wd[ia];
            end
            if (q_v[ia] && q_wa[ia] == raB && raB != '0) begin
                hitB = 1'b1;
                fwdB = q_wd[ia];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized bench for regfile_wb_queue against a queue-based model,
// plus directed scenarios with literal expectations.
module tb_regfile_wb_queue;

    localparam int N = 32;
    localparam int R = 5;
    localparam int DEPTH = 4;
    localparam int P = 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [R-1:0] in_wa;
    logic [N-1:0] in_wd;
    logic [R-1:0] wa;
    logic [N-1:0] wd;
    logic         wen;
    logic [R-1:0] raA;
    logic [R-1:0] raB;
    logic         hitA;
    logic         hitB;
    logic [N-1:0] fwdA;
    logic [N-1:0] fwdB;
    logic [P:0]   count;
    logic         empty;

    int checks = 0;
    int failures = 0;
    bit model_on = 0;

    logic [R-1:0] mq_a[$];
    logic [N-1:0] mq_d[$];
    logic         m_wen;
    logic [R-1:0] m_wa;
    logic [N-1:0] m_wd;

    regfile_wb_queue #(.N(N), .R(R), .DEPTH(DEPTH), .P(P)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wa(in_wa), .in_wd(in_wd),
        .wa(wa), .wd(wd), .wen(wen),
        .raA(raA), .raB(raB),
        .hitA(hitA), .hitB(hitB),
        .fwdA(fwdA), .fwdB(fwdB),
        .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq_a.delete();
        mq_d.delete();
        m_wen = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    // One clock edge of the behavioural model, using current inputs.
    task automatic model_step();
        bit acc;
        if (!reset) begin
            model_clear();
            return;
        end
        acc = in_valid && (mq_a.size() != DEPTH);
        if (mq_a.size() > 0) begin
            m_wen = 1'b1;
            m_wa = mq_a.pop_front();
            m_wd = mq_d.pop_front();
        end else begin
            m_wen = 1'b0;
        end
        if (acc && in_wa != 0) begin
            mq_a.push_back(in_wa);
            mq_d.push_back(in_wd);
        end
    endtask

    function automatic logic [N:0] model_fwd(input logic [R-1:0] ra);
        if (ra == 0) return '0;
        for (int i = mq_a.size() - 1; i >= 0; i--)
            if (mq_a[i] == ra) return {1'b1, mq_d[i]};
        if (m_wen && m_wa == ra) return {1'b1, m_wd};
        return '0;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [R-1:0] a,
                         input logic [N-1:0] d);
        in_valid = v;
        in_wa = a;
        in_wd = d;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        logic [N:0] fa;
        logic [N:0] fb;
        if (model_on && reset) begin
            fa = model_fwd(raA);
            fb = model_fwd(raB);
            chk("in_ready", 32'(in_ready), 32'(mq_a.size() != DEPTH));
            chk("wen", 32'(wen), 32'(m_wen));
            if (m_wen) begin
                chk("wa", 32'(wa), 32'(m_wa));
                chk("wd", wd, m_wd);
            end
            chk("count", 32'(count), 32'(mq_a.size()));
            chk("empty", 32'(empty), 32'(mq_a.size() == 0 && !m_wen));
            chk("hitA", 32'(hitA), 32'(fa[N]));
            chk("fwdA", fwdA, fa[N-1:0]);
            chk("hitB", 32'(hitB), 32'(fb[N]));
            chk("fwdB", fwdB, fb[N-1:0]);
        end
    end

    initial begin
        reset = 1'b0;
        drive(0, '0, '0);
        raA = '0;
        raB = '0;
        model_clear();
        repeat (2) tick();
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        model_on = 1;

        // Single push, one-cycle retire latency.
        tick();
        drive(1, 5'd5, 32'hA5A5A5A5);
        tick();
        drive(0, '0, '0);
        chk("t1_wen_pre", 32'(wen), 32'd0);
        tick();
        chk("t1_wen", 32'(wen), 32'd1);
        chk("t1_wa", 32'(wa), 32'd5);
        chk("t1_wd", wd, 32'hA5A5A5A5);
        tick();
        chk("t1_wen_off", 32'(wen), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);

        // Back-to-back burst of five: ready stays high, order kept.
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(i + 1), 32'h100 + 32'(i));
            #1 chk("t2_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drive(0, '0, '0);
        chk("t2_wa_first", 32'(wa), 32'd4);
        repeat (3) tick();

        // Pending r3=1 then r3=2: youngest forwarded.
        drive(1, 5'd3, 32'd1);
        tick();
        drive(1, 5'd3, 32'd2);
        tick();
        drive(0, '0, '0);
        raA = 5'd3;
        #1;
        chk("t4_hitA", 32'(hitA), 32'd1);
        chk("t4_fwdA", fwdA, 32'd2);
        repeat (2) tick();
        chk("t4_hitA_done", 32'(hitA), 32'd0);
        chk("t4_fwdA_done", fwdA, 32'd0);

        // Write to r0 is consumed and dropped.
        drive(1, 5'd0, 32'hFFFFFFFF);
        raA = 5'd0;
        #1 chk("t5_ready", 32'(in_ready), 32'd1);
        tick();
        drive(0, '0, '0);
        chk("t5_count", 32'(count), 32'd0);
        tick();
        chk("t5_wen", 32'(wen), 32'd0);
        chk("t5_hitA", 32'(hitA), 32'd0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(7 + i), 32'h200 + 32'(i));
            tick();
        end
        reset = 1'b0;
        model_clear();
        #1;
        chk("t6_wen", 32'(wen), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd1);
        drive(0, '0, '0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_nowrite", 32'(wen), 32'd0);
        end

        // Randomized traffic on a small address range to provoke hits.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  $urandom);
            raA = 5'($urandom_range(0, 7));
            raB = 5'($urandom_range(0, 7));
            tick();
        end
        drive(0, '0, '0);
        repeat (4) tick();
        chk("final_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
